// File: rtl/cv32e40s_glitch_sequencer.sv
// ---------------------------------------------------------------------------
// cv32e40s_glitch_sequencer
//
// Timed, multi-channel fault injector for lockstep fault campaigns.
// CHANNELS buses of WIDTH bits pass through a single register stage. Once
// armed and triggered, the block waits a programmed delay and then corrupts
// one selected channel. The corruption is masked and uses one of three modes
// (stuck-at, bit-flip or LFSR-random). It lasts a programmed number of cycles.
//
// Optional feature macro: GLITCH_SEQ_HIT_CNT_EN
//   When defined, hit_cnt_o counts completed (non-aborted) injections and
//   saturates at 16'hFFFF.
//
// Ports
//   clk          clock
//   rst          synchronous, active-high reset
//   arm_i        latch cfg_* and arm (accepted in IDLE only)
//   abort_i      cancel any sequence, back to IDLE next clock
//   cfg_mode_i   0 stuck, 1 flip, 2 random, 3 no-op
//   cfg_chan_i   target channel (values >= CHANNELS alter nothing)
//   cfg_mask_i   bits affected by the glitch
//   cfg_value_i  stuck-at value
//   cfg_delay_i  cycles from trigger to ACTIVE
//   cfg_dur_i    ACTIVE cycles (0 behaves as 1)
//   trig_i       start the delay (sampled in ARMED only)
//   sig_i        channel c = sig_i[c*WIDTH +: WIDTH]
//   sig_o        registered, possibly glitched, copy of sig_i
//   busy_o       state != IDLE
//   active_o     state == ACTIVE
//   done_o       one-cycle pulse after the last glitched output cycle
//   hit_cnt_o    completed injection count (GLITCH_SEQ_HIT_CNT_EN only)
// ---------------------------------------------------------------------------
module cv32e40s_glitch_sequencer #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned DELAY_W   = 16,
  parameter int unsigned DUR_W     = 8,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2024,
  localparam int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      arm_i,
  input  logic                      abort_i,
  input  logic [1:0]                cfg_mode_i,
  input  logic [CH_W-1:0]           cfg_chan_i,
  input  logic [WIDTH-1:0]          cfg_mask_i,
  input  logic [WIDTH-1:0]          cfg_value_i,
  input  logic [DELAY_W-1:0]        cfg_delay_i,
  input  logic [DUR_W-1:0]          cfg_dur_i,
  input  logic                      trig_i,
  input  logic [CHANNELS*WIDTH-1:0] sig_i,
  output logic [CHANNELS*WIDTH-1:0] sig_o,
  output logic                      busy_o,
  output logic                      active_o,
  output logic                      done_o
`ifdef GLITCH_SEQ_HIT_CNT_EN
  ,
  output logic [15:0]               hit_cnt_o
`endif
);

  localparam logic [1:0] MODE_STUCK  = 2'd0;
  localparam logic [1:0] MODE_FLIP   = 2'd1;
  localparam logic [1:0] MODE_RANDOM = 2'd2;

  // Galois feedback mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form).
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // An all-zero seed would lock the LFSR at zero forever.
  generate
    if (LFSR_SEED == 32'd0) begin : g_bad_seed
      $error("cv32e40s_glitch_sequencer: LFSR_SEED must be nonzero");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_WAIT,
    ST_ACTIVE,
    ST_DONE
  } state_t;

  state_t                      state_reg;
  logic [DELAY_W-1:0]          cnt_reg;
  logic [DUR_W-1:0]            dur_cnt_reg;
  logic [1:0]                  mode_reg;
  logic [CH_W-1:0]             chan_reg;
  logic [WIDTH-1:0]            mask_reg;
  logic [WIDTH-1:0]            value_reg;
  logic [DELAY_W-1:0]          delay_reg;
  logic [DUR_W-1:0]            dur_reg;
  logic                        done_reg;
  logic [31:0]                 lfsr_reg;
  logic [31:0]                 lfsr_next;
  logic [WIDTH-1:0]            rnd;
  logic [CHANNELS*WIDTH-1:0]   sig_reg;
  logic [CHANNELS*WIDTH-1:0]   sig_next;
  logic                        glitch_en;
`ifdef GLITCH_SEQ_HIT_CNT_EN
  logic [15:0]                 hit_cnt_reg;
`endif

  // -------------------------------------------------------------------------
  // Sequencer FSM. abort_i wins over every transition and also suppresses the
  // done pulse that a DONE-state cycle would otherwise produce.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      dur_cnt_reg <= '0;
      mode_reg    <= '0;
      chan_reg    <= '0;
      mask_reg    <= '0;
      value_reg   <= '0;
      delay_reg   <= '0;
      dur_reg     <= '0;
      done_reg    <= 1'b0;
`ifdef GLITCH_SEQ_HIT_CNT_EN
      hit_cnt_reg <= '0;
`endif
    end else if (abort_i) begin
      state_reg <= ST_IDLE;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (arm_i) begin
            mode_reg  <= cfg_mode_i;
            chan_reg  <= cfg_chan_i;
            mask_reg  <= cfg_mask_i;
            value_reg <= cfg_value_i;
            delay_reg <= cfg_delay_i;
            dur_reg   <= cfg_dur_i;
            state_reg <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (trig_i) begin
            cnt_reg <= delay_reg;
            // Duration is loaded here so it is ready for both the direct
            // (zero-delay) path and the path through WAIT.
            dur_cnt_reg <= (dur_reg == '0) ? DUR_W'(1) : dur_reg;
            state_reg   <= (delay_reg != '0) ? ST_WAIT : ST_ACTIVE;
          end
        end
        ST_WAIT: begin
          // Exit at 1 rather than 0 so the WAIT phase lasts exactly delay
          // cycles and the counter never wraps.
          cnt_reg <= cnt_reg - DELAY_W'(1);
          if (cnt_reg == DELAY_W'(1)) begin
            state_reg <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          dur_cnt_reg <= dur_cnt_reg - DUR_W'(1);
          if (dur_cnt_reg == DUR_W'(1)) begin
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          // The pulse appears in the cycle after DONE, aligned with the cycle
          // after the last glitched sig_o value.
          done_reg  <= 1'b1;
          state_reg <= ST_IDLE;
`ifdef GLITCH_SEQ_HIT_CNT_EN
          if (hit_cnt_reg != 16'hFFFF) begin
            hit_cnt_reg <= hit_cnt_reg + 16'd1;
          end
`endif
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Free-running LFSR, advancing every cycle regardless of FSM state.
  // -------------------------------------------------------------------------
  assign lfsr_next = {1'b0, lfsr_reg[31:1]} ^ ({32{lfsr_reg[0]}} & LFSR_TAPS);

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_reg <= LFSR_SEED;
    end else begin
      lfsr_reg <= lfsr_next;
    end
  end

  // The random word is the LFSR repeated LSB-first across the channel width.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_rnd
      assign rnd[gi] = lfsr_reg[gi % 32];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Per-channel glitch datapath. An out-of-range channel select never equals
  // any channel index, so nothing is altered in that case.
  // -------------------------------------------------------------------------
  assign glitch_en = (state_reg == ST_ACTIVE) && !abort_i;

  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [WIDTH-1:0] x;
      logic [WIDTH-1:0] g;
      logic             hit;

      assign x   = sig_i[gi*WIDTH +: WIDTH];
      assign hit = glitch_en && (chan_reg == CH_W'(gi));

      always_comb begin
        g = x;
        case (mode_reg)
          MODE_STUCK:  g = (x & ~mask_reg) | (value_reg & mask_reg);
          MODE_FLIP:   g = x ^ mask_reg;
          MODE_RANDOM: g = (x & ~mask_reg) | (rnd & mask_reg);
          default:     g = x;
        endcase
      end

      assign sig_next[gi*WIDTH +: WIDTH] = hit ? g : x;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_reg <= '0;
    end else begin
      sig_reg <= sig_next;
    end
  end

  assign sig_o    = sig_reg;
  assign busy_o   = (state_reg != ST_IDLE);
  assign active_o = (state_reg == ST_ACTIVE);
  assign done_o   = done_reg;
`ifdef GLITCH_SEQ_HIT_CNT_EN
  assign hit_cnt_o = hit_cnt_reg;
`endif

endmodule

// File: tb/tb_cv32e40s_glitch_sequencer.sv
// ---------------------------------------------------------------------------
// Bench for cv32e40s_glitch_sequencer (WIDTH=32, CHANNELS=2).
// Each injection is described by its trigger cycle T, delay d and effective
// duration D=max(dur,1). From those the bench derives, per cycle T+k:
//   busy   : k <= 1+d+D       active : 1+d <= k <= d+D
//   glitch : 2+d <= k <= 1+d+D  done : k == 2+d+D
// and an abort driven at cycle T+a clears everything for k > a.
// ---------------------------------------------------------------------------
module tb_cv32e40s_glitch_sequencer;

  localparam logic [31:0] SEED = 32'hACE1_2024;

  logic        clk = 1'b0;
  logic        rst;
  logic        arm_i;
  logic        abort_i;
  logic [1:0]  cfg_mode_i;
  logic [0:0]  cfg_chan_i;
  logic [31:0] cfg_mask_i;
  logic [31:0] cfg_value_i;
  logic [15:0] cfg_delay_i;
  logic [7:0]  cfg_dur_i;
  logic        trig_i;
  logic [63:0] sig_i;
  logic [63:0] sig_o;
  logic        busy_o;
  logic        active_o;
  logic        done_o;
`ifdef GLITCH_SEQ_HIT_CNT_EN
  logic [15:0] hit_cnt_o;
`endif

  always #5 clk = ~clk;

  cv32e40s_glitch_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .arm_i       (arm_i),
    .abort_i     (abort_i),
    .cfg_mode_i  (cfg_mode_i),
    .cfg_chan_i  (cfg_chan_i),
    .cfg_mask_i  (cfg_mask_i),
    .cfg_value_i (cfg_value_i),
    .cfg_delay_i (cfg_delay_i),
    .cfg_dur_i   (cfg_dur_i),
    .trig_i      (trig_i),
    .sig_i       (sig_i),
    .sig_o       (sig_o),
    .busy_o      (busy_o),
    .active_o    (active_o),
    .done_o      (done_o)
`ifdef GLITCH_SEQ_HIT_CNT_EN
    ,
    .hit_cnt_o   (hit_cnt_o)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  int          completed = 0;
  logic [31:0] lfsr_m;
  logic [63:0] prev_sig;
  logic [31:0] prev_rnd;
  bit          sig_rand;
  logic [63:0] sig_fix;
  logic [1:0]  r_mode;
  int          r_chan;
  logic [31:0] r_mask;
  logic [31:0] r_value;

  // Multiply by x modulo x^32+x^22+x^2+x+1, bit-reversed register view.
  function automatic logic [31:0] lfsr_adv(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) begin
      r[31] = ~r[31];
      r[21] = ~r[21];
      r[1]  = ~r[1];
      r[0]  = ~r[0];
    end
    return r;
  endfunction

  function automatic logic [31:0] gval(input logic [31:0] x, input logic [1:0] m,
                                       input logic [31:0] mask, input logic [31:0] value,
                                       input logic [31:0] rnd);
    case (m)
      2'd0:    return (x & ~mask) | (value & mask);
      2'd1:    return x ^ mask;
      2'd2:    return (x & ~mask) | (rnd & mask);
      default: return x;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    prev_sig = sig_i;
    prev_rnd = lfsr_m;
    @(posedge clk);
    lfsr_m = rst ? SEED : lfsr_adv(lfsr_m);
    #1;
  endtask

  task automatic drive_sig();
    sig_i = sig_rand ? {$urandom, $urandom} : sig_fix;
  endtask

  task automatic garbage_cfg();
    cfg_mode_i  = 2'($urandom_range(0, 3));
    cfg_chan_i  = 1'($urandom_range(0, 1));
    cfg_mask_i  = $urandom;
    cfg_value_i = $urandom;
    cfg_delay_i = 16'($urandom);
    cfg_dur_i   = 8'($urandom);
  endtask

  task automatic check_cycle(input string tag, input bit busy_e, input bit act_e,
                             input bit done_e, input bit glitch_e);
    logic [63:0] e;
    for (int c = 0; c < 2; c++) begin
      e[c*32 +: 32] = (glitch_e && c == r_chan)
                      ? gval(prev_sig[c*32 +: 32], r_mode, r_mask, r_value, prev_rnd)
                      : prev_sig[c*32 +: 32];
    end
    chk({tag, "_sig"}, sig_o, e);
    chk({tag, "_busy"}, 64'(busy_o), 64'(busy_e));
    chk({tag, "_active"}, 64'(active_o), 64'(act_e));
    chk({tag, "_done"}, 64'(done_o), 64'(done_e));
  endtask

  // One armed injection; abort_at < 0 means no abort, otherwise abort is
  // driven during cycle T+abort_at. Ends in the first IDLE cycle.
  task automatic run(input logic [1:0] mode, input int chan, input logic [31:0] mask,
                     input logic [31:0] value, input int d, input int du,
                     input int abort_at, input int pre);
    int dd;
    int last;
    bit alive;
    dd      = (du == 0) ? 1 : du;
    r_mode  = mode;
    r_chan  = chan;
    r_mask  = mask;
    r_value = value;
    arm_i       = 1'b1;
    cfg_mode_i  = mode;
    cfg_chan_i  = 1'(chan);
    cfg_mask_i  = mask;
    cfg_value_i = value;
    cfg_delay_i = 16'(d);
    cfg_dur_i   = 8'(du);
    trig_i      = 1'($urandom_range(0, 1));
    drive_sig();
    tick();
    check_cycle("armed", 1, 0, 0, 0);
    for (int i = 0; i < pre; i++) begin
      garbage_cfg();
      arm_i  = 1'($urandom_range(0, 1));
      trig_i = 1'b0;
      drive_sig();
      tick();
      check_cycle("armed_hold", 1, 0, 0, 0);
    end
    garbage_cfg();
    arm_i  = 1'($urandom_range(0, 1));
    trig_i = 1'b1;
    drive_sig();
    tick();
    last = (abort_at >= 0) ? abort_at + 1 : d + dd + 2;
    for (int k = 1; k <= last; k++) begin
      alive = (abort_at < 0) || (k <= abort_at);
      check_cycle($sformatf("run_k%0d", k), alive && k <= 1 + d + dd,
                  alive && k >= 1 + d && k <= d + dd, alive && k == 2 + d + dd,
                  alive && k >= 2 + d && k <= 1 + d + dd);
      if (k == last) break;
      garbage_cfg();
      abort_i = (k == abort_at);
      arm_i   = (k <= 1 + d + dd) ? 1'($urandom_range(0, 1)) : 1'b0;
      trig_i  = 1'($urandom_range(0, 1));
      drive_sig();
      tick();
      abort_i = 1'b0;
    end
    arm_i  = 1'b0;
    trig_i = 1'b0;
    if (abort_at < 0 || abort_at >= 2 + d + dd) completed++;
`ifdef GLITCH_SEQ_HIT_CNT_EN
    chk("hit_cnt", 64'(hit_cnt_o), 64'(completed));
`endif
    $display("run mode=%0d chan=%0d mask=%h delay=%0d dur=%0d abort=%0d checks=%0d errors=%0d",
             mode, chan, mask, d, du, abort_at, checks, errors);
  endtask

  initial begin
    int d;
    int du;
    int ab;
    rst = 1'b1;
    arm_i = 1'b0;
    abort_i = 1'b0;
    trig_i = 1'b0;
    cfg_mode_i = '0;
    cfg_chan_i = '0;
    cfg_mask_i = '0;
    cfg_value_i = '0;
    cfg_delay_i = '0;
    cfg_dur_i = '0;
    sig_rand = 1'b0;
    sig_fix = '1;
    lfsr_m = SEED;
    drive_sig();

    // Reset held two cycles with all-ones input.
    tick();
    chk("rst_sig", sig_o, 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_active", 64'(active_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
`ifdef GLITCH_SEQ_HIT_CNT_EN
    chk("rst_hit", 64'(hit_cnt_o), 64'd0);
`endif
    tick();
    chk("rst_sig2", sig_o, 64'd0);
    rst = 1'b0;
    tick();
    chk("rel_sig", sig_o, {64{1'b1}});
    $display("reset sequence checks=%0d errors=%0d", checks, errors);

    // Stuck-at on channel 1.
    run(2'd0, 1, 32'h0000_00FF, 32'h0, 3, 2, -1, 0);
    // Flip on channel 0 with zero delay and zero duration.
    sig_fix = {32'h1234_5678, 32'h0};
    run(2'd1, 0, 32'h8000_0001, 32'h0, 0, 0, -1, 1);
    // Abort in WAIT, then immediate re-arm.
    sig_rand = 1'b1;
    run(2'd1, 1, 32'hFFFF_FFFF, 32'h0, 100, 5, 10, 0);
    run(2'd0, 0, 32'hF0F0_F0F0, 32'hAAAA_5555, 1, 3, -1, 2);
    // Random mode on a zero input.
    sig_rand = 1'b0;
    sig_fix = 64'd0;
    run(2'd2, 0, 32'h0000_FFFF, 32'h0, 2, 5, -1, 0);
    run(2'd2, 1, 32'h0000_FFFF, 32'h0, 0, 4, -1, 1);
    // Trigger pulses in IDLE must not start anything.
    sig_rand = 1'b1;
    for (int i = 0; i < 4; i++) begin
      garbage_cfg();
      trig_i = 1'b1;
      drive_sig();
      tick();
      check_cycle("idle_trig", 0, 0, 0, 0);
    end
    trig_i = 1'b0;
    // No-op mode still sequences.
    run(2'd3, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 2, -1, 0);
    // Abort in DONE (no done pulse) and in ACTIVE.
    run(2'd1, 0, 32'hFFFF_FFFF, 32'h0, 1, 1, 3, 0);
    run(2'd1, 1, 32'h00FF_00FF, 32'h0, 2, 4, 4, 0);

    // Randomized injections.
    for (int n = 0; n < 24; n++) begin
      d  = $urandom_range(0, 6);
      du = $urandom_range(0, 4);
      ab = ($urandom_range(0, 9) < 3) ? $urandom_range(1, d + ((du == 0) ? 1 : du) + 2) : -1;
      sig_rand = ($urandom_range(0, 3) != 0);
      sig_fix = {$urandom, $urandom};
      run(2'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom, $urandom,
          d, du, ab, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
